// File: rtl/seq_chunk_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_subtractor
// Brief    : Multi-cycle WIDTH-bit subtractor. Subtracts CHUNK bits per clock
//            with the borrow held in a register between chunks. Operands are
//            accepted and results returned through valid/ready handshakes.
//            Optional macro SEQSUB_FLAGS_EN adds registered Zero and signed
//            overflow (Ovf) result flags.
// Revision : 1.0 - initial release
// ============================================================================
module seq_chunk_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SEQSUB_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic [IDXW-1:0]  idx_q,    idx_d;
    logic             borrow_q, borrow_d;
    logic             bout_q,   bout_d;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_d;
    logic             w_br;
    logic             w_last;

`ifdef SEQSUB_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q,  ovf_d;
    logic w_msb_bin;
`endif

    // Slice the current chunk and subtract it with the carried borrow
    always_comb begin
        w_a_chunk     = a_q[idx_q*CHUNK +: CHUNK];
        w_b_chunk     = b_q[idx_q*CHUNK +: CHUNK];
        {w_br, w_d}   = {1'b0, w_a_chunk} - {1'b0, w_b_chunk}
                        - {{CHUNK{1'b0}}, borrow_q};
        w_last        = (idx_q == C_LAST_IDX);
`ifdef SEQSUB_FLAGS_EN
        // For one bit, d = a ^ b ^ borrow_in, so the borrow into the MSB
        // can be recovered from the MSB operands and result.
        w_msb_bin     = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_d[CHUNK-1];
`endif
    end

    // Next-state logic of the IDLE -> RUN -> DONE sequencer
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef SEQSUB_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    idx_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                diff_d[idx_q*CHUNK +: CHUNK] = w_d;
                borrow_d = w_br;
                if (w_last) begin
                    // Index parks at 0 so the part-select never leaves range
                    idx_d   = '0;
                    bout_d  = w_br;
                    state_d = S_DONE;
`ifdef SEQSUB_FLAGS_EN
                    zero_d  = (diff_d == '0);
                    ovf_d   = w_msb_bin ^ w_br;
`endif
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
        end
    end

`ifdef SEQSUB_FLAGS_EN
    // Result flag registers, captured on the final RUN edge
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Zero = zero_q;
    assign Ovf  = ovf_q;
`endif

    // Handshake outputs decode registered state only
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Diff      = diff_q;
    assign Bout      = bout_q;

endmodule
`default_nettype wire
